grad_accum: RTL and testbench

GRAD_ACCUM -- requirements
Module: grad_accum

---
 rtl/grad_accum.sv | 134 +++++++++++++
 tb/tb_grad_accum.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/grad_accum.sv
// grad_accum
// Batched gradient accumulator for one weight of a fixed-point learning unit.
// Signed gradient terms are summed with saturation into an internal
// accumulator. After BATCH terms have been accepted, the block spends one
// cycle applying the batch: the weight becomes sat(weight - accumulated
// gradient). The accumulator and term counter are then cleared, and
// acceptance resumes on the next cycle.
//
// Ports
//   clk       single clock, rising edge
//   rst       synchronous active-high reset (highest priority)
//   i_load    loads i_init_w into the weight and restarts the batch
//   i_init_w  initial weight value (WIDTH bits, FRAC fractional bits)
//   i_valid   i_grad carries a gradient term this cycle
//   i_grad    signed gradient term, already in the WIDTH/FRAC format
//   o_ready   high while terms can be accepted (low during the apply cycle)
//   o_w       current registered weight
//   o_upd     one-cycle pulse marking a freshly updated o_w
//   o_cnt     number of terms accepted in the current batch
module grad_accum #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24,
    parameter int BATCH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_init_w,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_grad,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_w,
    output logic             o_upd,
    output logic [7:0]       o_cnt
);

    // The fixed-point format is only carried through; the block never
    // rescales, but a fraction wider than the word is meaningless.
    if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
        $error("grad_accum: FRAC must lie in 0..WIDTH-1");
    end
    if (BATCH < 1 || BATCH > 255) begin : g_bad_batch
        $error("grad_accum: BATCH must lie in 1..255");
    end

    localparam logic [0:0] ACC   = 1'b0;
    localparam logic [0:0] APPLY = 1'b1;

    localparam logic [WIDTH-1:0] MAX_POS   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [7:0]       BATCH_CNT = 8'(BATCH);

    logic [0:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] w;
    logic             upd;
    logic [7:0]       cnt;

    logic [WIDTH:0]   acc_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] acc_sat;
    logic [WIDTH-1:0] w_sat;
    logic [7:0]       cnt_inc;
    logic             transfer;

    // Both arithmetic paths are evaluated one bit wider than the word.
    // A disagreement between the top two bits means the true result left
    // the representable range; the extra sign bit then selects which rail
    // to clamp to.
    always_comb begin
        acc_sum = {acc[WIDTH-1], acc} + {i_grad[WIDTH-1], i_grad};
        w_diff  = {w[WIDTH-1], w} - {acc[WIDTH-1], acc};

        if (acc_sum[WIDTH] != acc_sum[WIDTH-1]) begin
            acc_sat = acc_sum[WIDTH] ? MIN_NEG : MAX_POS;
        end else begin
            acc_sat = acc_sum[WIDTH-1:0];
        end

        if (w_diff[WIDTH] != w_diff[WIDTH-1]) begin
            w_sat = w_diff[WIDTH] ? MIN_NEG : MAX_POS;
        end else begin
            w_sat = w_diff[WIDTH-1:0];
        end
    end

    assign o_ready  = (state == ACC);
    assign transfer = i_valid && o_ready;
    assign cnt_inc  = cnt + 8'd1;

    // Priority: reset, then load, then normal operation. A load discards
    // any partial batch and also cancels an apply that would otherwise
    // happen on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
            acc   <= '0;
            w     <= '0;
            cnt   <= '0;
            upd   <= 1'b0;
        end else if (i_load) begin
            state <= ACC;
            acc   <= '0;
            w     <= i_init_w;
            cnt   <= '0;
            upd   <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    upd <= 1'b0;
                    if (transfer) begin
                        acc <= acc_sat;
                        cnt <= cnt_inc;
                        if (cnt_inc == BATCH_CNT) begin
                            state <= APPLY;
                        end
                    end
                end
                default: begin
                    w     <= w_sat;
                    acc   <= '0;
                    cnt   <= '0;
                    upd   <= 1'b1;
                    state <= ACC;
                end
            endcase
        end
    end

    assign o_w   = w;
    assign o_upd = upd;
    assign o_cnt = cnt;

endmodule

// File: tb/tb_grad_accum.sv
// tb_grad_accum
// Directed bench for grad_accum (BATCH=4), with a second BATCH=1 instance
// driven by the same inputs. It finishes with a short random-valid run
// against a behavioural reference model.
module tb_grad_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_load;
    logic [31:0] i_init_w;
    logic        i_valid;
    logic [31:0] i_grad;

    logic        o_ready;
    logic [31:0] o_w;
    logic        o_upd;
    logic [7:0]  o_cnt;

    logic        o_ready1;
    logic [31:0] o_w1;
    logic        o_upd1;
    logic [7:0]  o_cnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    grad_accum #(.WIDTH(32), .FRAC(24), .BATCH(4)) dut (
        .clk(clk), .rst(rst), .i_load(i_load), .i_init_w(i_init_w),
        .i_valid(i_valid), .i_grad(i_grad), .o_ready(o_ready),
        .o_w(o_w), .o_upd(o_upd), .o_cnt(o_cnt)
    );

    grad_accum #(.WIDTH(32), .FRAC(24), .BATCH(1)) dut1 (
        .clk(clk), .rst(rst), .i_load(i_load), .i_init_w(i_init_w),
        .i_valid(i_valid), .i_grad(i_grad), .o_ready(o_ready1),
        .o_w(o_w1), .o_upd(o_upd1), .o_cnt(o_cnt1)
    );

    // Advance one rising edge, then settle before outputs are sampled.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Saturating reference arithmetic done in 64-bit integers.
    function automatic logic [31:0] satv(input longint v);
        logic [63:0] tmp;
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        tmp = 64'(v);
        return tmp[31:0];
    endfunction

    logic [31:0] m_w;
    logic [31:0] m_acc;
    int          m_cnt;
    bit          m_apply;
    bit          m_upd;
    int          xfers;
    int          upds;
    int          stalls;

    initial begin
        rst      = 1'b1;
        i_load   = 1'b0;
        i_init_w = '0;
        i_valid  = 1'b0;
        i_grad   = '0;
        applyStimulus();
        rst = 1'b0;
        checkOutput("reset_w", o_w, 32'h0);
        checkOutput("reset_cnt", 32'(o_cnt), 32'd0);
        checkOutput("reset_upd", 32'(o_upd), 32'd0);
        checkOutput("reset_ready", 32'(o_ready), 32'd1);

        // Load 1.0, then four terms of 0.25 bring the weight to 0.
        i_load = 1'b1; i_init_w = 32'h0100_0000;
        applyStimulus();
        i_load = 1'b0;
        checkOutput("load_w", o_w, 32'h0100_0000);
        i_valid = 1'b1; i_grad = 32'h0040_0000;
        applyStimulus();
        checkOutput("b1_cnt", 32'(o_cnt1), 32'd1);
        checkOutput("b1_apply_ready", 32'(o_ready1), 32'd0);
        applyStimulus();
        checkOutput("b1_w", o_w1, 32'h00C0_0000);
        checkOutput("b1_upd", 32'(o_upd1), 32'd1);
        applyStimulus();
        checkOutput("s1_cnt3", 32'(o_cnt), 32'd3);
        checkOutput("s1_ready_acc", 32'(o_ready), 32'd1);
        applyStimulus();
        checkOutput("s1_apply_ready", 32'(o_ready), 32'd0);
        checkOutput("s1_apply_cnt", 32'(o_cnt), 32'd4);
        checkOutput("s1_apply_upd", 32'(o_upd), 32'd0);
        checkOutput("s1_apply_w", o_w, 32'h0100_0000);
        i_valid = 1'b0;
        applyStimulus();
        checkOutput("s1_new_w", o_w, 32'h0);
        checkOutput("s1_upd", 32'(o_upd), 32'd1);
        checkOutput("s1_cnt0", 32'(o_cnt), 32'd0);
        checkOutput("s1_ready_back", 32'(o_ready), 32'd1);
        applyStimulus();
        checkOutput("s1_upd_drop", 32'(o_upd), 32'd0);

        // Saturation on both the accumulator and the weight.
        i_load = 1'b1; i_init_w = 32'h7FFF_FF00;
        applyStimulus();
        i_load = 1'b0;
        i_valid = 1'b1; i_grad = 32'hC000_0000;
        for (int i = 0; i < 4; i++) applyStimulus();
        i_valid = 1'b0;
        applyStimulus();
        checkOutput("sat_w", o_w, 32'h7FFF_FFFF);
        checkOutput("sat_upd", 32'(o_upd), 32'd1);

        // i_valid held for ten cycles: two batches, two stall slots.
        i_load = 1'b1; i_init_w = 32'h0;
        applyStimulus();
        i_load = 1'b0;
        i_valid = 1'b1; i_grad = 32'h0001_0000;
        xfers = 0; upds = 0; stalls = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_ready) xfers++;
            else stalls++;
            applyStimulus();
            if (o_upd) upds++;
        end
        i_valid = 1'b0;
        checkOutput("stream_xfers", 32'(xfers), 32'd8);
        checkOutput("stream_stalls", 32'(stalls), 32'd2);
        checkOutput("stream_upds", 32'(upds), 32'd2);
        checkOutput("stream_w", o_w, 32'hFFF8_0000);

        // A load on the edge of the 4th transfer wins over the batch.
        i_load = 1'b1; i_init_w = 32'h0100_0000;
        applyStimulus();
        i_load = 1'b0;
        i_valid = 1'b1; i_grad = 32'h0040_0000;
        for (int i = 0; i < 3; i++) applyStimulus();
        i_load = 1'b1; i_init_w = 32'h00AB_CDEF;
        applyStimulus();
        i_load = 1'b0; i_valid = 1'b0;
        checkOutput("ldovr_w", o_w, 32'h00AB_CDEF);
        checkOutput("ldovr_cnt", 32'(o_cnt), 32'd0);
        checkOutput("ldovr_upd", 32'(o_upd), 32'd0);
        checkOutput("ldovr_ready", 32'(o_ready), 32'd1);
        applyStimulus();
        checkOutput("ldovr_no_upd", 32'(o_upd), 32'd0);
        checkOutput("ldovr_w_hold", o_w, 32'h00AB_CDEF);

        // Reset mid-batch discards the partial sum.
        i_load = 1'b1; i_init_w = 32'h0;
        applyStimulus();
        i_load = 1'b0;
        i_valid = 1'b1; i_grad = 32'h0020_0000;
        applyStimulus();
        applyStimulus();
        checkOutput("rstmid_cnt2", 32'(o_cnt), 32'd2);
        rst = 1'b1; i_valid = 1'b0;
        applyStimulus();
        rst = 1'b0;
        checkOutput("rstmid_cnt0", 32'(o_cnt), 32'd0);
        i_load = 1'b1; i_init_w = 32'h0;
        applyStimulus();
        i_load = 1'b0;
        i_valid = 1'b1; i_grad = 32'h0010_0000;
        for (int i = 0; i < 4; i++) applyStimulus();
        i_valid = 1'b0;
        applyStimulus();
        checkOutput("rstmid_w", o_w, 32'hFFC0_0000);
        checkOutput("rstmid_upd", 32'(o_upd), 32'd1);

        // Random valid pattern against the reference model.
        i_load = 1'b1; i_init_w = 32'h0123_4567;
        applyStimulus();
        i_load = 1'b0;
        m_w = 32'h0123_4567; m_acc = '0; m_cnt = 0; m_apply = 1'b0; m_upd = 1'b0;
        for (int i = 0; i < 300; i++) begin
            i_valid = ($urandom_range(0, 2) != 0);
            i_grad  = ($urandom_range(0, 3) == 0) ? $urandom()
                                                 : 32'($signed($urandom_range(0, 32'h00FF_FFFF)) - 32'sh0080_0000);
            if (m_apply) begin
                m_w = satv(longint'($signed(m_w)) - longint'($signed(m_acc)));
                m_acc = '0; m_cnt = 0; m_apply = 1'b0; m_upd = 1'b1;
            end else begin
                m_upd = 1'b0;
                if (i_valid) begin
                    m_acc = satv(longint'($signed(m_acc)) + longint'($signed(i_grad)));
                    m_cnt++;
                    if (m_cnt == 4) m_apply = 1'b1;
                end
            end
            applyStimulus();
            checkOutput("rand_upd", 32'(o_upd), 32'(m_upd));
            checkOutput("rand_cnt", 32'(o_cnt), 32'(m_cnt));
            if (o_upd) checkOutput("rand_w", o_w, m_w);
        end
        i_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
